menu_fsm: RTL and testbench
===========================

// Module: menu_fsm
// PURPOSE
//  Front-end game-phase controller, directly upstream of the 3-2-1-GO countdown stage.
//  - Handles menu navigation and selects a game mode.
//  - Issues the one-cycle start pulse that launches the countdown, then tracks the countdown's active flag.
//  - Gates gameplay with play_en and returns to the menu a fixed time after game over.
//  - All timing is in frames: clk is the 60 Hz frame tick.
// PARAMETERS
//  NUM_OPTIONS    3    number of selectable menu entries, 2..2**SEL_W
//  SEL_W          2    width of menu_sel / mode
//  HOLD_FRAMES    3    consecutive frames confirm must be held to accept, >=1
//  ARM_TIMEOUT    4    frames to wait for cd_active after start before aborting, >=2
//  RETURN_FRAMES  120  frames spent in game-over before returning to menu, >=1
// PORTS
//  clk          in   1      60 Hz frame clock
//  reset        in   1      asynchronous, active-high reset
//  btn_up       in   1      raw level, already synchronised to clk
//  btn_down     in   1      raw level, already synchronised to clk
//  btn_confirm  in   1      raw level, already synchronised to clk
//  cd_active    in   1      countdown running flag, from the countdown stage
//  game_over    in   1      level/pulse from game logic
//  menu_sel     out  SEL_W  currently highlighted entry
//  mode         out  SEL_W  latched selection for the game in progress
//  start        out  1      one-cycle pulse to the countdown stage
//  menu_active  out  1      high in S_MENU
//  play_en      out  1      high in S_PLAY
//  arm_fail     out  1      sticky; set on ARM timeout, cleared by the next start
// BEHAVIOUR
//  Interface: one clock, clk. reset is asynchronous and active-high.
//  Reset values:
//   - state=S_MENU, menu_sel=0, mode=0, start=0, arm_fail=0.
//   - All counters 0, button history regs 0, confirm_armed=0.
//  Edge detect: up/down act on rising edges, registered previous sample vs current.
//  States: S_MENU -> S_ARM -> S_COUNT -> S_PLAY -> S_OVER -> S_MENU.
//  S_MENU:
//   - confirm_armed is set once btn_confirm is seen low in S_MENU; hold_cnt counts only while armed.
//   - Navigation on up edge: menu_sel-1. On down edge: menu_sel+1.
//   - Simultaneous up+down edges: no change.
//   - Navigation edges are ignored while hold_cnt != 0.
//   - btn_confirm high while armed: hold_cnt++. Low: hold_cnt=0.
//   - On the HOLD_FRAMES-th consecutive high frame: start=1 for exactly that next cycle, mode<=menu_sel, arm_fail<=0, go S_ARM.
//   - The hold is accepted even if an up/down edge arrives on the same cycle; navigation is discarded.
//  S_ARM:
//   - cd_active=1 -> S_COUNT.
//   - Otherwise timer++. At ARM_TIMEOUT frames with no cd_active: arm_fail<=1, -> S_MENU, confirm_armed=0.
//  S_COUNT:
//   - cd_active falls to 0 -> S_PLAY.
//   - game_over is ignored here.
//  S_PLAY:
//   - game_over=1 -> S_OVER with timer=0.
//   - Buttons are ignored.
//  S_OVER:
//   - Counts RETURN_FRAMES cycles, then -> S_MENU with confirm_armed=0.
//   - menu_sel and mode are retained.
//  Outputs:
//   - start, menu_active and play_en are registered.
//   - start never asserts outside the S_MENU->S_ARM transition.
//   - mode is stable from start until the next start.
//  Reset mid-operation: immediate return to reset values in any state; no start pulse is emitted.
// CONFIGURATION
//  MENU_WRAP_EN defined:
//   - menu_sel wraps: 0 up -> NUM_OPTIONS-1; NUM_OPTIONS-1 down -> 0.
//  MENU_WRAP_EN undefined:
//   - menu_sel saturates at 0 and at NUM_OPTIONS-1; edges beyond the ends are ignored.
// TESTING
//  1. Reset, then confirm high 3 frames after 1 low frame -> start pulse on 1 cycle only, mode=0, menu_active drops.
//  2. Two down edges, then confirm held -> mode=2. Down edge at sel=2:
//     - MENU_WRAP_EN: sel=0.
//     - Without: sel=2.
//  3. Countdown model raises cd_active 1 cycle after start, holds 120 cycles -> S_COUNT, then play_en=1 the cycle after cd_active falls.
//  4. cd_active held 0 after start -> arm_fail=1 after 4 frames, menu_active=1. Next accepted start clears arm_fail.
//  5. game_over in S_PLAY -> play_en=0, menu_active=1 exactly 120 frames later.
//     Confirm still held from play -> no start until it is released and re-held 3 frames.
//  6. Assert reset during S_COUNT and during the confirm hold -> all outputs at reset values, no start pulse.

Source files
------------

// File: rtl/menu_fsm.sv
// Game-phase controller ahead of the 3-2-1-GO countdown: menu navigation, mode select, start, play gating.
// Build option MENU_WRAP_EN: menu_sel wraps at both ends instead of saturating.
module menu_fsm #(
    parameter int NUM_OPTIONS   = 3,
    parameter int SEL_W         = 2,
    parameter int HOLD_FRAMES   = 3,
    parameter int ARM_TIMEOUT   = 4,
    parameter int RETURN_FRAMES = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_confirm,
    input  logic             cd_active,
    input  logic             game_over,
    output logic [SEL_W-1:0] menu_sel,
    output logic [SEL_W-1:0] mode,
    output logic             start,
    output logic             menu_active,
    output logic             play_en,
    output logic             arm_fail,
    output logic [2:0]       state_dbg
);

    localparam logic [2:0] S_MENU  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_PLAY  = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam int TIMER_MAX = (ARM_TIMEOUT > RETURN_FRAMES) ? ARM_TIMEOUT : RETURN_FRAMES;
    localparam int TW        = $clog2(TIMER_MAX + 1);
    localparam int HW        = $clog2(HOLD_FRAMES + 1);

    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_OPTIONS - 1);
    localparam logic [TW-1:0]    ARM_LAST  = TW'(ARM_TIMEOUT - 1);
    localparam logic [TW-1:0]    RET_LAST  = TW'(RETURN_FRAMES - 1);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_FRAMES - 1);

    logic [2:0]       state, state_n;
    logic [SEL_W-1:0] sel_n, mode_n;
    logic [TW-1:0]    timer, timer_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic             armed, armed_n;
    logic             start_n, arm_fail_n;
    logic             up_q, down_q;
    logic             up_edge, down_edge;

    assign up_edge   = btn_up & ~up_q;
    assign down_edge = btn_down & ~down_q;
    assign state_dbg = state;

    always_comb begin
        state_n    = state;
        sel_n      = menu_sel;
        mode_n     = mode;
        timer_n    = timer;
        hold_n     = hold_cnt;
        armed_n    = armed;
        start_n    = 1'b0;
        arm_fail_n = arm_fail;
        case (state)
            S_MENU: begin
                // A confirm already held on entry must be released before it can count.
                if (!btn_confirm) armed_n = 1'b1;
                if (armed && btn_confirm) begin
                    if (hold_cnt == HOLD_LAST) begin
                        start_n    = 1'b1;
                        mode_n     = menu_sel;
                        arm_fail_n = 1'b0;
                        state_n    = S_ARM;
                        timer_n    = '0;
                        hold_n     = '0;
                        armed_n    = 1'b0;
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end else begin
                    hold_n = '0;
                end
                if (!start_n && hold_cnt == '0 && (up_edge ^ down_edge)) begin
                    if (up_edge) begin
                        if (menu_sel != '0) sel_n = menu_sel - SEL_W'(1);
`ifdef MENU_WRAP_EN
                        else                sel_n = SEL_LAST;
`endif
                    end else begin
                        if (menu_sel != SEL_LAST) sel_n = menu_sel + SEL_W'(1);
`ifdef MENU_WRAP_EN
                        else                      sel_n = '0;
`endif
                    end
                end
            end
            S_ARM: begin
                if (cd_active) begin
                    state_n = S_COUNT;
                end else if (timer == ARM_LAST) begin
                    arm_fail_n = 1'b1;
                    state_n    = S_MENU;
                    armed_n    = 1'b0;
                    hold_n     = '0;
                    timer_n    = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_COUNT: begin
                if (!cd_active) state_n = S_PLAY;
            end
            S_PLAY: begin
                if (game_over) begin
                    state_n = S_OVER;
                    timer_n = '0;
                end
            end
            S_OVER: begin
                if (timer == RET_LAST) begin
                    state_n = S_MENU;
                    armed_n = 1'b0;
                    hold_n  = '0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = S_MENU;
        endcase
    end

    // Flags are registered from the next state so they line up with state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_MENU;
            menu_sel    <= '0;
            mode        <= '0;
            timer       <= '0;
            hold_cnt    <= '0;
            armed       <= 1'b0;
            start       <= 1'b0;
            arm_fail    <= 1'b0;
            menu_active <= 1'b1;
            play_en     <= 1'b0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
        end else begin
            state       <= state_n;
            menu_sel    <= sel_n;
            mode        <= mode_n;
            timer       <= timer_n;
            hold_cnt    <= hold_n;
            armed       <= armed_n;
            start       <= start_n;
            arm_fail    <= arm_fail_n;
            menu_active <= (state_n == S_MENU);
            play_en     <= (state_n == S_PLAY);
            up_q        <= btn_up;
            down_q      <= btn_down;
        end
    end

endmodule

// File: tb/tb_menu_fsm.sv
// Directed bench for menu_fsm: start handshake, navigation limits, arm timeout, play/over timing, reset.
module tb_menu_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_confirm, cd_active, game_over;
    logic [1:0] menu_sel, mode;
    logic       start, menu_active, play_en, arm_fail;
    logic [2:0] state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_sel;

    menu_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_confirm (btn_confirm),
        .cd_active   (cd_active),
        .game_over   (game_over),
        .menu_sel    (menu_sel),
        .mode        (mode),
        .start       (start),
        .menu_active (menu_active),
        .play_en     (play_en),
        .arm_fail    (arm_fail),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"},      menu_sel,    0);
        check({tag, "_mode"},     mode,        0);
        check({tag, "_start"},    start,       0);
        check({tag, "_armfail"},  arm_fail,    0);
        check({tag, "_menu"},     menu_active, 1);
        check({tag, "_play"},     play_en,     0);
    endtask

    initial begin
        reset = 1'b1;
        btn_up = 0; btn_down = 0; btn_confirm = 0; cd_active = 0; game_over = 0;
        step(2);
        check_reset_values("reset");
        reset = 1'b0;

        // First start: one low frame arms, then three high frames.
        step(1);
        btn_confirm = 1;
        step(1); check("t1_start_h1", start, 0);
        step(1); check("t1_start_h2", start, 0);
        step(1);
        check("t1_start_pulse", start, 1);
        check("t1_mode", mode, 0);
        check("t1_menu_drop", menu_active, 0);
        step(1); check("t1_start_once", start, 0);

        // No cd_active: arm timeout four frames after entering arm.
        step(2);
        check("t4_armfail_early", arm_fail, 0);
        check("t4_menu_early", menu_active, 0);
        step(1);
        check("t4_armfail", arm_fail, 1);
        check("t4_menu_back", menu_active, 1);

        // Two down edges then hold confirm.
        btn_confirm = 0; btn_down = 1;
        step(1); check("t2_sel1", menu_sel, 1);
        btn_down = 0;
        step(1);
        btn_down = 1;
        step(1); check("t2_sel2", menu_sel, 2);
        btn_down = 0; btn_confirm = 1;
        step(1);
        btn_up = 1;
        step(1); check("t2_nav_ignored_in_hold", menu_sel, 2);
        btn_up = 0;
        step(1);
        check("t2_start_pulse", start, 1);
        check("t2_mode", mode, 2);
        check("t4_armfail_cleared", arm_fail, 0);

        // Countdown model: cd_active one cycle after start, high for 120 cycles.
        step(1);
        check("t3_start_once", start, 0);
        cd_active = 1; game_over = 1;
        step(1);
        check("t3_in_count_menu", menu_active, 0);
        check("t3_in_count_play", play_en, 0);
        step(119);
        check("t3_count_ignores_over", play_en, 0);
        check("t3_count_menu", menu_active, 0);
        cd_active = 0; game_over = 0;
        step(1);
        check("t3_play_en", play_en, 1);

        // Game over with confirm still held from play.
        game_over = 1;
        step(1);
        check("t5_play_drop", play_en, 0);
        game_over = 0;
        step(119);
        check("t5_menu_early", menu_active, 0);
        step(1);
        check("t5_menu_back", menu_active, 1);
        check("t5_mode_kept", mode, 2);
        check("t5_sel_kept", menu_sel, 2);
        step(5);
        check("t5_no_start_held", start, 0);
        btn_confirm = 0;
        step(1);
        btn_confirm = 1;
        step(2); check("t5_start_h2", start, 0);
        step(1); check("t5_start_rehold", start, 1);
        step(3); check("t5_armfail_early", arm_fail, 0);
        step(1); check("t5_armfail", arm_fail, 1);

        // Navigation limits at the last entry, then at the low side.
        btn_confirm = 0; btn_down = 1;
`ifdef MENU_WRAP_EN
        exp_sel = 2'd0;
`else
        exp_sel = 2'd2;
`endif
        step(1); check("t2_down_at_last", menu_sel, {30'd0, exp_sel});
        btn_down = 0; btn_up = 1;
`ifdef MENU_WRAP_EN
        exp_sel = 2'd2;
`else
        exp_sel = 2'd1;
`endif
        step(1); check("t2_up_after_edge", menu_sel, {30'd0, exp_sel});
        btn_up = 0;

        // Reset during the countdown.
        btn_confirm = 1;
        step(3); check("t6_start", start, 1);
        cd_active = 1;
        step(1); check("t6_in_count", menu_active, 0);
        reset = 1;
        #1;
        check_reset_values("t6_rst_count");
        step(1);
        cd_active = 0; reset = 0;

        // Reset during the confirm hold.
        btn_confirm = 0;
        step(1);
        btn_confirm = 1;
        step(2);
        reset = 1;
        #1;
        check_reset_values("t6_rst_hold");
        step(1);
        reset = 0;
        step(4);
        check("t6_no_start_after", start, 0);
        check("t6_menu_after", menu_active, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
